// File: rtl/ring_phase_monitor_if.sv
// ring_phase_monitor_if: phase bus from the ring counter plus the monitor's status outputs.
interface ring_phase_monitor_if #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 16
);
   localparam int IDX_W = $clog2(WIDTH);
   logic [WIDTH-1:0] phase_in;
   logic             in_vld;
   logic             clr_err;
   logic [IDX_W-1:0] phase_idx;
   logic             idx_vld;
   logic             locked;
   logic             fault;
   logic [1:0]       err_code;
   logic [CNT_W-1:0] rot_cnt;
   modport master (
      output phase_in, in_vld, clr_err,
      input  phase_idx, idx_vld, locked, fault, err_code, rot_cnt
   );
   modport slave (
      input  phase_in, in_vld, clr_err,
      output phase_idx, idx_vld, locked, fault, err_code, rot_cnt
   );
endinterface

// File: rtl/ring_phase_monitor.sv
// ring_phase_monitor: checks a one-hot rotate-left phase bus, reports lock/fault, phase index and rotations.
// Optional gap watchdog while locked is enabled by defining RPM_STUCK_DET_EN.
module ring_phase_monitor #(
   parameter int WIDTH     = 4,
   parameter int LOCK_CNT  = 4,
   parameter int CNT_W     = 16,
   parameter int STUCK_MAX = 8
) (
   input logic clk,
   input logic rst_n,
   ring_phase_monitor_if.slave bus
);
   localparam int IDX_W = $clog2(WIDTH);
   localparam int GC_W  = $clog2(LOCK_CNT + 1);
   typedef enum logic [1:0] {UNLOCKED, LOCKED, FAULT} state_t;
   state_t state, state_n;
   logic [WIDTH-1:0] prev, prev_n;
   logic prev_v, prev_v_n;
   logic [GC_W-1:0] good_cnt, good_n, good_inc;
   logic [1:0] err, err_n;
   logic [CNT_W-1:0] rot, rot_n;
   logic [IDX_W-1:0] idx, enc;
   logic idx_v;
   logic zero, multi, legal, in_seq, wd_trip;
   assign zero     = ~|bus.phase_in;
   assign multi    = |(bus.phase_in & (bus.phase_in - WIDTH'(1)));
   assign legal    = !zero && !multi;
   assign in_seq   = legal && prev_v && bus.phase_in == {prev[WIDTH-2:0], prev[WIDTH-1]};
   assign good_inc = good_cnt + GC_W'(1);
   assign bus.locked    = state == LOCKED;
   assign bus.fault     = state == FAULT;
   assign bus.err_code  = err;
   assign bus.rot_cnt   = rot;
   assign bus.phase_idx = idx;
   assign bus.idx_vld   = idx_v;
   always_comb begin
      enc = '0;
      for (int i = 0; i < WIDTH; i++) enc = bus.phase_in[i] ? IDX_W'(i) : enc;
   end
`ifdef RPM_STUCK_DET_EN
   localparam int WD_W = $clog2(STUCK_MAX + 1);
   logic [WD_W-1:0] wd, wd_inc, wd_n;
   logic wd_run;
   assign wd_run  = state == LOCKED && !bus.in_vld && !bus.clr_err;
   assign wd_inc  = wd + WD_W'(1);
   assign wd_trip = wd_run && wd_inc == WD_W'(STUCK_MAX);
   assign wd_n    = (wd_run && !wd_trip) ? wd_inc : '0;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) wd <= '0;
      else wd <= wd_n;
   end
`else
   assign wd_trip = 1'b0;
`endif
   always_comb begin
      state_n  = state;
      prev_n   = prev;
      prev_v_n = prev_v;
      good_n   = good_cnt;
      err_n    = err;
      rot_n    = rot;
      if (bus.clr_err) begin
         state_n  = UNLOCKED;
         prev_v_n = 1'b0;
         good_n   = '0;
         err_n    = 2'b00;
         rot_n    = '0;
      end else if (wd_trip) begin
         state_n = FAULT;
         err_n   = 2'b00;
      end else if (bus.in_vld && state == UNLOCKED) begin
         prev_n   = bus.phase_in;
         prev_v_n = legal;
         good_n   = in_seq ? good_inc : '0;
         if (in_seq && good_inc == GC_W'(LOCK_CNT)) begin
            state_n = LOCKED;
            good_n  = '0;
         end
      end else if (bus.in_vld && state == LOCKED) begin
         // in-sequence one-hot landing on bit 0 is the wrap that closes a rotation
         if (in_seq) begin
            prev_n = bus.phase_in;
            rot_n  = bus.phase_in[0] ? rot + CNT_W'(1) : rot;
         end else begin
            state_n = FAULT;
            err_n   = zero ? 2'b01 : multi ? 2'b10 : 2'b11;
         end
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= UNLOCKED;
         prev     <= '0;
         prev_v   <= 1'b0;
         good_cnt <= '0;
         err      <= 2'b00;
         rot      <= '0;
         idx      <= '0;
         idx_v    <= 1'b0;
      end else begin
         state    <= state_n;
         prev     <= prev_n;
         prev_v   <= prev_v_n;
         good_cnt <= good_n;
         err      <= err_n;
         rot      <= rot_n;
         idx_v    <= bus.in_vld && legal;
         if (bus.in_vld && legal) idx <= enc;
      end
   end
endmodule
